obstacle_lane_engine: RTL and testbench

// Parametrised obstacle manager for the VGA runner game: NUM_OBS independent obstacle slots

---
 rtl/obstacle_lane_engine.sv | 134 +++++++++++++
 tb/tb_obstacle_lane_engine.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/obstacle_lane_engine.sv
// obstacle_lane_engine: scrolling obstacle slots with spawn spacing, player collision and run/dead/won tracking
module obstacle_lane_engine #(
  parameter int NUM_OBS   = 4,
  parameter int XW        = 10,
  parameter int SPAWN_X   = 680,
  parameter int SPEED     = 2,
  parameter int MIN_GAP   = 120,
  parameter int OBS_W     = 30,
  parameter int OBS_H     = 25,
  parameter int GROUND_Y  = 400,
  parameter int WIN_COUNT = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick_i,
  input  logic                  start_i,
  input  logic                  spawn_req_i,
  input  logic [XW-1:0]         player_left_i,
  input  logic [XW-1:0]         player_right_i,
  input  logic [XW-1:0]         player_top_i,
  input  logic [XW-1:0]         player_bot_i,
  input  logic [XW-1:0]         px_i,
  input  logic [XW-1:0]         py_i,
  output logic                  obs_pixel_o,
  output logic [NUM_OBS*XW-1:0] obs_x_o,
  output logic [NUM_OBS-1:0]    obs_active_o,
  output logic                  spawn_ack_o,
  output logic [7:0]            cleared_cnt_o,
  output logic [1:0]            state_o,
  output logic                  dead_o,
  output logic                  win_o
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD, WON} state_t;
  localparam int IW = NUM_OBS > 1 ? $clog2(NUM_OBS) : 1;
  localparam logic [XW:0]   W     = (XW+1)'(OBS_W);
  localparam logic [XW:0]   TOP   = (XW+1)'(GROUND_Y - OBS_H);
  localparam logic [XW:0]   GND   = (XW+1)'(GROUND_Y);
  localparam logic [XW-1:0] SPD   = XW'(SPEED);
  localparam logic [XW-1:0] SPX   = XW'(SPAWN_X);
  localparam logic [XW-1:0] GAP_X = XW'(SPAWN_X - MIN_GAP);
  localparam logic [7:0]    WC    = 8'(WIN_COUNT);

  state_t               state_q, state_d;
  logic [XW-1:0]        x_q [NUM_OBS];
  logic [XW-1:0]        x_d [NUM_OBS];
  logic [NUM_OBS-1:0]   act_q, act_d, hit, pix;
  logic [IW-1:0]        newest_q, newest_d, sp_idx;
  logic [7:0]           cleared_q, cleared_d;
  logic [8:0]           cnt;
  logic                 ack_q, ack_d, spawn;

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == RUN) state_d = |hit ? DEAD : (cleared_q >= WC) ? WON : RUN;
    else if (start_i)   state_d = RUN;
  end

  always_comb begin
    state_o       = state_q;
    dead_o        = state_q == DEAD;
    win_o         = state_q == WON;
    obs_active_o  = act_q;
    spawn_ack_o   = ack_q;
    cleared_cnt_o = cleared_q;
    obs_pixel_o   = state_q != IDLE && |pix;
    obs_x_o       = '0;
    for (int i = 0; i < NUM_OBS; i++) obs_x_o[i*XW +: XW] = x_q[i];
  end

  // The pixel is treated as a 1x1 box, so the exclusive edges become inclusive compares.
  always_comb begin
    hit = '0;
    pix = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      hit[i] = act_q[i] && x_q[i] < player_right_i && {1'b0, x_q[i]} + W > {1'b0, player_left_i}
               && TOP < {1'b0, player_bot_i} && GND > {1'b0, player_top_i};
      pix[i] = act_q[i] && x_q[i] <= px_i && {1'b0, x_q[i]} + W > {1'b0, px_i}
               && TOP <= {1'b0, py_i} && GND > {1'b0, py_i};
    end
  end

  always_comb begin
    x_d      = x_q;
    act_d    = act_q;
    newest_d = newest_q;
    ack_d    = 1'b0;
    cnt      = {1'b0, cleared_q};
    sp_idx   = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) if (!act_q[i]) sp_idx = IW'(i);
    // Spawn decisions use pre-tick occupancy and the newest slot's pre-tick position.
    spawn = state_q == RUN && frame_tick_i && spawn_req_i && !(&act_q)
            && (!(|act_q) || x_q[newest_q] <= GAP_X);
    if (state_q != RUN && start_i) begin
      for (int i = 0; i < NUM_OBS; i++) x_d[i] = '0;
      act_d    = '0;
      cnt      = '0;
      newest_d = '0;
    end else if (state_q == RUN && frame_tick_i) begin
      for (int i = 0; i < NUM_OBS; i++)
        if (act_q[i]) begin
          if (x_q[i] <= SPD) begin
            act_d[i] = 1'b0;
            cnt      = cnt + 9'd1;
          end else x_d[i] = x_q[i] - SPD;
        end
      if (spawn) begin
        x_d[sp_idx]   = SPX;
        act_d[sp_idx] = 1'b1;
        newest_d      = sp_idx;
        ack_d         = 1'b1;
      end
    end
    cleared_d = cnt[8] ? 8'hFF : cnt[7:0];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_OBS; i++) x_q[i] <= '0;
      act_q     <= '0;
      newest_q  <= '0;
      cleared_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      x_q       <= x_d;
      act_q     <= act_d;
      newest_q  <= newest_d;
      cleared_q <= cleared_d;
      ack_q     <= ack_d;
    end
endmodule

// File: tb/tb_obstacle_lane_engine.sv
// tb_obstacle_lane_engine: directed scoreboard bench for obstacle_lane_engine
module tb_obstacle_lane_engine;
  logic clk = 0, reset = 1, frame_tick = 0, start = 0, spawn_req = 0;
  logic [9:0] pl = 0, pr = 0, pt = 0, pb = 0, px = 0, py = 0;
  logic obs_pixel, spawn_ack, dead, win;
  logic [39:0] obs_x;
  logic [3:0] obs_active;
  logic [7:0] cleared;
  logic [1:0] state;
  int total = 0, bad = 0, acks = 0;

  typedef struct { string tag; logic [63:0] v; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  obstacle_lane_engine dut (
    .clk(clk), .reset(reset), .frame_tick_i(frame_tick), .start_i(start), .spawn_req_i(spawn_req),
    .player_left_i(pl), .player_right_i(pr), .player_top_i(pt), .player_bot_i(pb),
    .px_i(px), .py_i(py), .obs_pixel_o(obs_pixel), .obs_x_o(obs_x), .obs_active_o(obs_active),
    .spawn_ack_o(spawn_ack), .cleared_cnt_o(cleared), .state_o(state), .dead_o(dead), .win_o(win)
  );

  function automatic logic [9:0] xs(int i);
    return obs_x[i*10 +: 10];
  endfunction

  task automatic want(string t, logic [63:0] e);
    exp_t x;
    x.tag = t;
    x.v = e;
    sb.push_back(x);
  endtask

  task automatic chk(logic [63:0] o);
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (o === e.v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic req);
    spawn_req = req;
    frame_tick = 1;
    step();
    frame_tick = 0;
    spawn_req = 0;
    if (spawn_ack) acks++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and first spawn
    step(); step();
    want("rst_state", 0); want("rst_act", 0); want("rst_clr", 0); want("rst_ack", 0); want("rst_pix", 0); want("rst_x", 0);
    chk(state); chk(obs_active); chk(cleared); chk(spawn_ack); chk(obs_pixel); chk(obs_x);
    reset = 0;
    start = 1;
    step();
    start = 0;
    want("start_run", 1); chk(state);
    want("sp1_x0", 680); want("sp1_act", 1); want("sp1_ack", 1);
    tick(1);
    chk(xs(0)); chk(obs_active); chk(spawn_ack);
    want("sp1_ack_drop", 0);
    step();
    chk(spawn_ack);
    // spacing: second spawn only on the 61st tick
    acks = 0;
    want("gap_act", 1); want("gap_x0", 560); want("gap_acks", 0);
    repeat (60) tick(1);
    chk(obs_active); chk(xs(0)); chk(acks);
    want("sp2_act", 3); want("sp2_x1", 680); want("sp2_x0", 558); want("sp2_ack", 1);
    tick(1);
    chk(obs_active); chk(xs(1)); chk(xs(0)); chk(spawn_ack);
    // pixel boundaries around slot0 at 558
    px = 558; py = 390; #1; want("pix_in", 1); chk(obs_pixel);
    px = 588; #1; want("pix_right", 0); chk(obs_pixel);
    px = 560; py = 375; #1; want("pix_top", 1); chk(obs_pixel);
    py = 374; #1; want("pix_above", 0); chk(obs_pixel);
    py = 400; #1; want("pix_ground", 0); chk(obs_pixel);
    // despawn at x=2 and count
    want("pre_clr_x0", 2); want("pre_clr_x1", 124); want("pre_clr_cnt", 0);
    repeat (278) tick(0);
    chk(xs(0)); chk(xs(1)); chk(cleared);
    want("clr_act", 2); want("clr_cnt", 1);
    tick(0);
    chk(obs_active); chk(cleared);
    // run on to 20 clears -> WON
    for (int n = 0; n < 3000 && cleared != 19; n++) tick(1);
    want("c19_cnt", 19); want("c19_state", 1);
    chk(cleared); chk(state);
    for (int n = 0; n < 200 && cleared != 20; n++) tick(1);
    want("c20_cnt", 20); want("c20_state", 1);
    chk(cleared); chk(state);
    want("won_state", 3); want("won_win", 1); want("won_dead", 0);
    step();
    chk(state); chk(win); chk(dead);
    want("won_hold_state", 3); want("won_hold_cnt", 20); want("won_no_ack", 0);
    tick(1);
    chk(state); chk(cleared); chk(spawn_ack);
    // collision edge: player [220,250)x[360,400)
    start = 1;
    step();
    start = 0;
    want("r2_state", 1); want("r2_cnt", 0); want("r2_act", 0);
    chk(state); chk(cleared); chk(obs_active);
    pl = 220; pr = 250; pt = 360; pb = 400;
    tick(1);
    repeat (214) tick(0);
    want("c_x252", 252); want("c_s252", 1); chk(xs(0)); chk(state);
    tick(0);
    want("c_x250", 250); chk(xs(0));
    step();
    want("c_s250", 1); chk(state);
    tick(0);
    want("c_x248", 248); want("c_s248", 1); chk(xs(0)); chk(state);
    step();
    want("dead_state", 2); want("dead_flag", 1); want("dead_x", 248);
    chk(state); chk(dead); chk(xs(0));
    tick(0);
    want("dead_hold_x", 248); want("dead_hold_state", 2);
    chk(xs(0)); chk(state);
    // all slots full + spawn on a clearing tick -> rejected
    pr = 0;
    start = 1;
    step();
    start = 0;
    acks = 0;
    repeat (340) tick(1);
    want("full_acks", 4); want("full_act", 15); want("full_x0", 2); want("full_x3", 368); want("full_cnt", 0);
    chk(acks); chk(obs_active); chk(xs(0)); chk(xs(3)); chk(cleared);
    want("rej_act", 14); want("rej_ack", 0); want("rej_cnt", 1);
    tick(1);
    chk(obs_active); chk(spawn_ack); chk(cleared);
    want("refill_act", 15); want("refill_x0", 680); want("refill_ack", 1);
    tick(1);
    chk(obs_active); chk(xs(0)); chk(spawn_ack);
    // asynchronous reset mid-run
    px = 690; py = 390;
    reset = 1;
    #2;
    want("ar_state", 0); want("ar_act", 0); want("ar_cnt", 0); want("ar_x", 0); want("ar_ack", 0); want("ar_pix", 0);
    chk(state); chk(obs_active); chk(cleared); chk(obs_x); chk(spawn_ack); chk(obs_pixel);
    reset = 0;
    step();
    start = 1;
    step();
    start = 0;
    want("fresh_state", 1); chk(state);
    want("fresh_x0", 680); want("fresh_act", 1); want("fresh_cnt", 0);
    tick(1);
    chk(xs(0)); chk(obs_active); chk(cleared);
    // hit and 20th clear in the same cycle -> DEAD
    for (int n = 0; n < 3000 && cleared != 20; n++) tick(1);
    want("hw_cnt", 20); want("hw_state", 1);
    chk(cleared); chk(state);
    pl = 0; pr = 1023; pt = 0; pb = 1023;
    step();
    want("hw_dead_state", 2); want("hw_dead", 1); want("hw_win", 0);
    chk(state); chk(dead); chk(win);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
